// File: rtl/int_wb_arbiter_if.sv
// Bundle for int_wb_arbiter: source queues, writeback port and flush.
// With INT_WB_SCOREBOARD_EN defined it also carries iss_valid/iss_rd/rd_busy.
interface int_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 3
);
    logic [NSRC-1:0]      src_valid;
    logic [NSRC-1:0]      src_ready;
    logic [5*NSRC-1:0]    src_rd;
    logic [XLEN*NSRC-1:0] src_data;
    logic                 flush;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [XLEN-1:0]      wb_data;
`ifdef INT_WB_SCOREBOARD_EN
    logic                 iss_valid;
    logic [4:0]           iss_rd;
    logic [31:0]          rd_busy;

    modport master (
        output src_valid, src_rd, src_data, flush, iss_valid, iss_rd,
        input  src_ready, wb_en, wb_addr, wb_data, rd_busy
    );
    modport slave (
        input  src_valid, src_rd, src_data, flush, iss_valid, iss_rd,
        output src_ready, wb_en, wb_addr, wb_data, rd_busy
    );
`else
    modport master (
        output src_valid, src_rd, src_data, flush,
        input  src_ready, wb_en, wb_addr, wb_data
    );
    modport slave (
        input  src_valid, src_rd, src_data, flush,
        output src_ready, wb_en, wb_addr, wb_data
    );
`endif
endinterface

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: per-source {rd,data} FIFOs merged onto one
// register-file write port. Define INT_WB_SCOREBOARD_EN to add the rd_busy scoreboard.
module int_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int NSRC     = 3,
    parameter int DEPTH    = 2,
    parameter int ARB_MODE = 0
) (
    input logic             clk,
    input logic             rst,
    int_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [SW:0] NSRC_W   = (SW+1)'(NSRC);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          r_mem  [NSRC][DEPTH];
    logic [AW:0]     r_wptr [NSRC];
    logic [AW:0]     r_rptr [NSRC];
    logic [NSRC-1:0] r_ready;
    logic [SW-1:0]   r_rr_ptr;
    logic            r_wb_en;
    logic [4:0]      r_wb_addr;
    logic [XLEN-1:0] r_wb_data;

    logic [NSRC-1:0]   w_nonempty;
    logic [NSRC-1:0]   w_push;
    logic [NSRC-1:0]   w_pop;
    logic [AW:0]       w_cnt_nxt [NSRC];
    logic              w_grant_vld;
    logic [SW-1:0]     w_grant;
    logic [SW-1:0]     w_off;
    logic [SW:0]       w_sum;
    logic [2*NSRC-1:0] w_dbl;
    entry_t            w_head;

    // rd = 0 handshakes complete normally but never reach the queue.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_nonempty[i] = (r_wptr[i] != r_rptr[i]);
            w_push[i]     = bus.src_valid[i] && r_ready[i] && (bus.src_rd[5*i +: 5] != 5'd0);
        end
    end

    always_comb begin
        w_grant_vld = |w_nonempty;
        w_grant     = '0;
        w_off       = '0;
        w_sum       = '0;
        w_dbl       = '0;
        if (ARB_MODE == 0) begin
            for (int i = NSRC-1; i >= 0; i--)
                if (w_nonempty[i]) w_grant = SW'(i);
        end else begin
            // Rotate the request vector so bit 0 is rr_ptr, then unrotate the winner.
            w_dbl = {w_nonempty, w_nonempty} >> r_rr_ptr;
            for (int k = NSRC-1; k >= 0; k--)
                if (w_dbl[k]) w_off = SW'(k);
            w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
            w_grant = (w_sum >= NSRC_W) ? SW'(w_sum - NSRC_W) : SW'(w_sum);
        end
        w_pop = '0;
        if (w_grant_vld) w_pop[w_grant] = 1'b1;
        w_head = r_mem[w_grant][r_rptr[w_grant][AW-1:0]];
        for (int i = 0; i < NSRC; i++)
            w_cnt_nxt[i] = r_wptr[i] - r_rptr[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
    end

    // NOTE: queue storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++)
            if (w_push[i])
                r_mem[i][r_wptr[i][AW-1:0]] <= {bus.src_rd[5*i +: 5], bus.src_data[XLEN*i +: XLEN]};
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
            r_ready   <= '0;
            r_rr_ptr  <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NSRC; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
            r_ready  <= '1;
            r_rr_ptr <= '0;
            r_wb_en  <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + (AW+1)'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + (AW+1)'(1);
                r_ready[i] <= (w_cnt_nxt[i] != CNT_FULL);
            end
            r_wb_en <= w_grant_vld;
            if (w_grant_vld) begin
                r_wb_addr <= w_head.rd;
                r_wb_data <= w_head.data;
                r_rr_ptr  <= (w_grant == SW'(NSRC-1)) ? '0 : w_grant + SW'(1);
            end
        end
    end

    assign bus.src_ready = r_ready;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_addr   = r_wb_addr;
    assign bus.wb_data   = r_wb_data;

`ifdef INT_WB_SCOREBOARD_EN
    logic [31:0] r_rd_busy;
    logic [31:0] w_busy_nxt;

    // Set is applied after clear so a same-cycle reissue keeps the bit pending.
    always_comb begin
        w_busy_nxt = r_rd_busy;
        if (r_wb_en)       w_busy_nxt[r_wb_addr]  = 1'b0;
        if (bus.iss_valid) w_busy_nxt[bus.iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) r_rd_busy <= '0;
        else                  r_rd_busy <= w_busy_nxt;
    end

    assign bus.rd_busy = r_rd_busy;
`endif
endmodule

// File: tb/tb_int_wb_arbiter.sv
// Scoreboard bench for int_wb_arbiter: a fixed-priority and a round-robin instance,
// expected writes queued at stimulus time and popped by negedge monitors.
module tb_int_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int NSRC  = 3;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    int_wb_arbiter_if #(.XLEN(XLEN), .NSRC(NSRC)) if_fp ();
    int_wb_arbiter_if #(.XLEN(XLEN), .NSRC(NSRC)) if_rr ();

    int_wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .ARB_MODE(0)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (if_fp)
    );
    int_wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .ARB_MODE(1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_rr)
    );

    typedef struct {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t q_fp[$];
    exp_t q_rr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wb(input bit rr, input logic [4:0] addr, input logic [XLEN-1:0] data, input int at);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = at;
        if (rr) q_rr.push_back(e);
        else    q_fp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rr, input int s, input logic [4:0] rd, input logic [XLEN-1:0] d);
        if (rr) begin
            if_rr.src_valid[s]           = 1'b1;
            if_rr.src_rd[5*s +: 5]       = rd;
            if_rr.src_data[XLEN*s +: XLEN] = d;
        end else begin
            if_fp.src_valid[s]           = 1'b1;
            if_fp.src_rd[5*s +: 5]       = rd;
            if_fp.src_data[XLEN*s +: XLEN] = d;
        end
    endtask

    task automatic idle();
        if_fp.src_valid = '0;
        if_rr.src_valid = '0;
    endtask

    always @(negedge clk) begin
        if (if_fp.wb_en === 1'b1) begin
            if (q_fp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fp_unexpected_write: got addr %0d data %0h, expected no write (cycle %0d)",
                         if_fp.wb_addr, if_fp.wb_data, cyc);
            end else begin
                exp_t e;
                e = q_fp.pop_front();
                check("fp_wb_addr", 64'(if_fp.wb_addr), 64'(e.addr));
                check("fp_wb_data", 64'(if_fp.wb_data), 64'(e.data));
                check("fp_wb_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (if_rr.wb_en === 1'b1) begin
            if (q_rr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rr_unexpected_write: got addr %0d data %0h, expected no write (cycle %0d)",
                         if_rr.wb_addr, if_rr.wb_data, cyc);
            end else begin
                exp_t e;
                e = q_rr.pop_front();
                check("rr_wb_addr", 64'(if_rr.wb_addr), 64'(e.addr));
                check("rr_wb_data", 64'(if_rr.wb_data), 64'(e.data));
                check("rr_wb_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int idx1;
        if_fp.src_valid = '0; if_fp.src_rd = '0; if_fp.src_data = '0; if_fp.flush = 1'b0;
        if_rr.src_valid = '0; if_rr.src_rd = '0; if_rr.src_data = '0; if_rr.flush = 1'b0;
`ifdef INT_WB_SCOREBOARD_EN
        if_fp.iss_valid = 1'b0; if_fp.iss_rd = '0;
        if_rr.iss_valid = 1'b0; if_rr.iss_rd = '0;
`endif
        rst = 1'b1;

        // Reset state, then ready rises on the first edge with rst low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fp_ready", 64'(if_fp.src_ready), 64'(0));
        check("rst_rr_ready", 64'(if_rr.src_ready), 64'(0));
        check("rst_fp_wb_en", 64'(if_fp.wb_en), 64'(0));
        check("rst_fp_wb_addr", 64'(if_fp.wb_addr), 64'(0));
        check("rst_fp_wb_data", 64'(if_fp.wb_data), 64'(0));
        tick();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_fp_ready", 64'(if_fp.src_ready), 64'h7);
        check("post_rst_rr_ready", 64'(if_rr.src_ready), 64'h7);
        tick();

        // Single write from source 2.
        c = cyc;
        drive(0, 2, 5'd5, 32'h0000_1234);
        expect_wb(0, 5'd5, 32'h0000_1234, c + 2);
        tick();
        check("single_ready2", 64'(if_fp.src_ready[2]), 64'(1));
        idle();
        tick();
        tick();
        @(negedge clk);
        check("hold_wb_en", 64'(if_fp.wb_en), 64'(0));
        check("hold_wb_addr", 64'(if_fp.wb_addr), 64'(5));
        check("hold_wb_data", 64'(if_fp.wb_data), 64'h1234);
        tick();

        // Fixed-priority contention.
        c = cyc;
        drive(0, 0, 5'd1, 32'h11);
        drive(0, 1, 5'd2, 32'h22);
        drive(0, 2, 5'd3, 32'h33);
        expect_wb(0, 5'd1, 32'h11, c + 2);
        expect_wb(0, 5'd2, 32'h22, c + 3);
        expect_wb(0, 5'd3, 32'h33, c + 4);
        tick();
        idle();
        repeat (5) tick();

        // Source 0 busy for 5 cycles starves source 1, which fills after 2 accepts.
        c = cyc;
        idx1 = 0;
        for (int j = 0; j < 5; j++) expect_wb(0, 5'd20, 32'hA00 + j, c + 2 + j);
        for (int j = 0; j < 3; j++) expect_wb(0, 5'(21 + j), 32'hE00 + j, c + 7 + j);
        for (int k = 0; k < 12; k++) begin
            idle();
            if (k < 5) drive(0, 0, 5'd20, 32'hA00 + k);
            if (k == 0) drive(0, 2, 5'd0, 32'hDEAD);
            if (k == 2) check("full_ready1", 64'(if_fp.src_ready[1]), 64'(0));
            if (idx1 < 3) begin
                drive(0, 1, 5'(21 + idx1), 32'hE00 + idx1);
                if (if_fp.src_ready[1]) idx1++;
            end
            tick();
        end
        idle();

        // Round-robin: all sources held valid for 6 cycles.
        c = cyc;
        for (int j = 0; j < 10; j++) expect_wb(1, 5'(10 + j % 3), 32'hB00 + j % 3, c + 2 + j);
        for (int s = 0; s < NSRC; s++) drive(1, s, 5'(10 + s), 32'hB00 + s);
        repeat (6) tick();
        idle();
        repeat (8) tick();

        // Flush mid-stream; the same-cycle enqueue on source 0 is dropped.
        c = cyc;
        for (int s = 0; s < NSRC; s++) drive(0, s, 5'(1 + s), 32'hF0 + s);
        expect_wb(0, 5'd1, 32'hF0, c + 2);
        tick();
        tick();
        idle();
        drive(0, 0, 5'd9, 32'h999);
        if_fp.flush = 1'b1;
        tick();
        idle();
        if_fp.flush = 1'b0;
        @(negedge clk);
        check("flush_wb_en", 64'(if_fp.wb_en), 64'(0));
        check("flush_ready", 64'(if_fp.src_ready), 64'h7);
        repeat (6) tick();

        // Reset mid-stream.
        c = cyc;
        for (int s = 0; s < NSRC; s++) drive(0, s, 5'(1 + s), 32'hC0 + s);
        expect_wb(0, 5'd1, 32'hC0, c + 2);
        tick();
        tick();
        idle();
        drive(0, 0, 5'd9, 32'h999);
        rst = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_wb_en", 64'(if_fp.wb_en), 64'(0));
        check("mid_rst_wb_addr", 64'(if_fp.wb_addr), 64'(0));
        check("mid_rst_wb_data", 64'(if_fp.wb_data), 64'(0));
        check("mid_rst_ready", 64'(if_fp.src_ready), 64'(0));
        tick();
        @(negedge clk);
        check("mid_rst_ready_back", 64'(if_fp.src_ready), 64'h7);
        repeat (6) tick();

`ifdef INT_WB_SCOREBOARD_EN
        if_fp.iss_valid = 1'b1;
        if_fp.iss_rd    = 5'd7;
        tick();
        if_fp.iss_valid = 1'b0;
        @(negedge clk);
        check("sb_set7", 64'(if_fp.rd_busy), 64'h80);
        tick();
        c = cyc;
        drive(0, 2, 5'd7, 32'h77);
        expect_wb(0, 5'd7, 32'h77, c + 2);
        tick();
        idle();
        tick();
        if_fp.iss_valid = 1'b1;
        if_fp.iss_rd    = 5'd7;
        tick();
        if_fp.iss_valid = 1'b0;
        @(negedge clk);
        check("sb_set_and_clear", 64'(if_fp.rd_busy), 64'h80);
        tick();
        c = cyc;
        drive(0, 2, 5'd7, 32'h78);
        expect_wb(0, 5'd7, 32'h78, c + 2);
        tick();
        idle();
        tick();
        tick();
        @(negedge clk);
        check("sb_clear7", 64'(if_fp.rd_busy), 64'h0);
        tick();
        if_fp.iss_valid = 1'b1;
        if_fp.iss_rd    = 5'd0;
        tick();
        if_fp.iss_valid = 1'b0;
        @(negedge clk);
        check("sb_rd0_ignored", 64'(if_fp.rd_busy), 64'h0);
        tick();
        if_fp.iss_valid = 1'b1;
        if_fp.iss_rd    = 5'd3;
        tick();
        if_fp.iss_valid = 1'b0;
        @(negedge clk);
        check("sb_set3", 64'(if_fp.rd_busy), 64'h8);
        tick();
        if_fp.flush = 1'b1;
        tick();
        if_fp.flush = 1'b0;
        @(negedge clk);
        check("sb_flush", 64'(if_fp.rd_busy), 64'h0);
        tick();
`endif

        repeat (4) tick();
        check("fp_queue_drained", 64'(q_fp.size()), 64'(0));
        check("rr_queue_drained", 64'(q_rr.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_wb_arbiter.md
INT_WB_ARBITER -- requirements
Module: int_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, integer result and write-data width.
REQ-002 Parameter NSRC, default 3, number of writeback sources (0 = CSR read, 1 = FPU-to-integer result, 2 = ALU/ADDI/LUI).
REQ-003 Parameter DEPTH, default 2, per-source queue depth; power of two, >= 2.
REQ-004 Parameter ARB_MODE, default 0, arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 src_valid  in  NSRC  per-source write request.
REQ-008 src_ready  out  NSRC  per-source queue not full.
REQ-009 src_rd  in  5*NSRC  per-source destination register; source i occupies bits [5i+4:5i].
REQ-010 src_data  in  XLEN*NSRC  per-source write data; source i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-011 flush  in  1  discards all queued writes.
REQ-012 wb_en  out  1  register-file write strobe.
REQ-013 wb_addr  out  5  register-file write address.
REQ-014 wb_data  out  XLEN  register-file write data.
REQ-015 iss_valid  in  1  instruction issued with a pending rd (present only under the macro).
REQ-016 iss_rd  in  5  destination register of the issued instruction (present only under the macro).
REQ-017 rd_busy  out  32  per-register pending-write bits (present only under the macro).

Function
REQ-018 Each source SHALL own a FIFO of DEPTH entries holding {rd, data}.
REQ-019 src_ready[i] SHALL be the registered not-full state of FIFO i; a pop in the same cycle SHALL NOT raise ready.
REQ-020 A transfer SHALL occur when src_valid[i] and src_ready[i] are both high; an entry with rd = 0 SHALL be accepted and then discarded, not enqueued.
REQ-021 Each cycle the arbiter SHALL select at most one non-empty FIFO head, pop it, and register it onto wb_addr/wb_data with wb_en = 1 at the next edge.
REQ-022 Latency: a write accepted at edge N into an empty queue, with no competing source, SHALL appear with wb_en = 1 during the cycle after edge N+1.
REQ-023 wb_en SHALL be high for exactly one cycle per popped entry; when no write occurs, wb_addr and wb_data SHALL hold their previous values.
REQ-024 ARB_MODE = 0: the lowest-index non-empty source SHALL win.
REQ-025 ARB_MODE = 1: search SHALL start at rr_ptr; after a grant to source g, rr_ptr SHALL become (g+1) mod NSRC; with no grant, rr_ptr SHALL be unchanged.
REQ-026 Entries from the same source SHALL be written in acceptance order; no ordering is guaranteed across sources.
REQ-027 Throughput SHALL be one write per cycle while any FIFO is non-empty.
REQ-028 flush SHALL, at the next edge, empty all FIFOs, set wb_en = 0, and reset rr_ptr to 0.
REQ-029 flush SHALL take priority over an enqueue or pop in the same cycle.
REQ-030 An enqueue and a pop on the same non-full FIFO in the same cycle SHALL both take effect, leaving the occupancy unchanged.

Reset
REQ-031 While rst is high, the following SHALL be forced at each edge: all FIFOs empty, pointers 0, rr_ptr 0, wb_en 0, wb_addr 0, wb_data 0, rd_busy 0, src_ready all 0.
REQ-032 In the first cycle after rst falls, src_ready SHALL be all 1.
REQ-033 rst asserted mid-operation SHALL discard all queued writes, with no partial write emitted.

Configuration
REQ-034 Macro INT_WB_SCOREBOARD_EN SHALL control the scoreboard feature.
REQ-035 With INT_WB_SCOREBOARD_EN defined: iss_valid with iss_rd != 0 SHALL set rd_busy[iss_rd] at the edge.
REQ-036 With the macro defined: wb_en = 1 SHALL clear rd_busy[wb_addr].
REQ-037 With the macro defined: a set and a clear of the same bit in the same cycle SHALL leave the bit set.
REQ-038 With the macro defined: flush SHALL clear all of rd_busy, and rd_busy[0] SHALL be constant 0.
REQ-039 Without INT_WB_SCOREBOARD_EN: iss_valid, iss_rd and rd_busy SHALL be absent and no scoreboard flops SHALL be inferred; all other behaviour SHALL be identical.

Verification
REQ-040 Single write: src 2 writes rd = 5, data = 0x0000_1234 -> wb_en = 1, wb_addr = 5, wb_data = 0x1234, two cycles after the valid cycle; src_ready stays 1.
REQ-041 Contention, ARB_MODE = 0: srcs 0/1/2 valid together with rd = 1/2/3 -> writes occur on three consecutive cycles in the order 1, 2, 3.
REQ-042 Round-robin, ARB_MODE = 1: all three sources held continuously valid for 6 cycles -> grant order 0, 1, 2, 0, 1, 2.
REQ-043 Full/ready: src 1 pushes 3 back-to-back while src 0 is continuously busy, DEPTH = 2 -> src_ready[1] = 0 after 2 accepts; the third entry is written after src 0 goes idle; rd = 0 pushes produce no wb_en.
REQ-044 Flush/reset mid-stream: 2 entries queued per source, then flush (repeat with rst) -> wb_en = 0 the next cycle and thereafter; no queued data is ever written.
REQ-045 Scoreboard (macro defined): iss rd = 7 -> rd_busy[7] = 1; writeback to rd 7 in the same cycle as a new iss rd = 7 -> rd_busy[7] stays 1; a later writeback alone -> rd_busy[7] = 0.
